// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared definitions for the snake move sequencer.
//   - DIR_* : 2-bit direction encoding (00 up, 01 down, 10 left, 11 right).
//             The encoding is chosen so that flipping bit 0 gives the
//             opposite direction on the same axis.
//   - state_t : controller FSM states.
//   - DEF_* : default playfield geometry (160x120 grid).
//   - dir_reverse() : opposite direction of a given direction.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_CALC   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  localparam int DEF_XW    = 8;
  localparam int DEF_YW    = 7;
  localparam int DEF_X_MAX = 159;
  localparam int DEF_Y_MAX = 119;

  // Up<->down and left<->right differ only in bit 0.
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_body_shift.sv
// snake_body_shift
//   One coordinate (X or Y) of the snake body, held as a flat vector of
//   MAX_LEN segments of N bits each; segment i lives at [N*i +: N] and
//   segment 0 is the head.
//   On load, every segment moves one place toward the tail and head_in is
//   written into segment 0. The old last live segment therefore lands in the
//   next slot, which is exactly the value a newly grown tail must take.
//   Requires MAX_LEN >= 2.
//
// Ports
//   Clock   : clock
//   Resetn  : synchronous active-low reset; all segments return to INIT
//   load    : shift enable (one cycle per committed move)
//   head_in : new segment 0 value
//   body    : flat segment vector
module snake_body_shift #(
  parameter int N       = 8,
  parameter int MAX_LEN = 8,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 load,
  input  logic [N-1:0]         head_in,
  output logic [N*MAX_LEN-1:0] body
);

  logic [N*MAX_LEN-1:0] body_reg;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      body_reg <= {MAX_LEN{INIT}};
    end else if (load) begin
      // Drop the top slot, insert the new head at the bottom.
      body_reg <= {body_reg[N*(MAX_LEN-1)-1:0], head_in};
    end
  end

  assign body = body_reg;

endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl
//   Per-tick snake move sequencer. Divides Clock down to a move tick, turns
//   the head according to a latched direction, checks the candidate head
//   against the walls (CALC) and then against the body one segment per
//   cycle (SCAN), and finally shifts the body in (COMMIT). Owns head, body,
//   length, committed direction and the sticky game-over flag.
//
// Ports
//   Clock, Resetn : clock and synchronous active-low reset
//   dir_req       : requested direction (00 up, 01 down, 10 left, 11 right)
//   dir_valid     : dir_req is sampled this cycle
//   grow          : one-cycle pulse, lengthen by one on the next commit
//   head_x/head_y : segment 0 coordinates
//   body_x/body_y : flat segment vectors, segment i at [W*i +: W]
//   length        : number of live segments
//   step_done     : one-cycle pulse in the first cycle the new body shows
//   game_over     : sticky collision flag
//   dir           : direction of the last committed move
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 8,
  parameter int TICK_DIV = 5000000,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int INIT_X   = 80,
  parameter int INIT_Y   = 60
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic [1:0]                   dir_req,
  input  logic                         dir_valid,
  input  logic                         grow,
  output logic [XW-1:0]                head_x,
  output logic [YW-1:0]                head_y,
  output logic [XW*MAX_LEN-1:0]        body_x,
  output logic [YW*MAX_LEN-1:0]        body_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         step_done,
  output logic                         game_over,
  output logic [1:0]                   dir
);

  localparam int LW = $clog2(MAX_LEN+1);
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t          state_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic [1:0]      pend_dir_reg;   // latest accepted request
  logic [1:0]      move_dir_reg;   // direction frozen at CALC for this move
  logic [1:0]      dir_reg;        // committed direction
  logic            grow_pend_reg;
  logic [LW-1:0]   length_reg;
  logic            step_done_reg;
  logic            game_over_reg;
  logic [XW-1:0]   cand_x_reg;
  logic [YW-1:0]   cand_y_reg;
  logic [IW-1:0]   scan_idx_reg;
  logic [LW-1:0]   scan_last_reg;  // index of the last segment to compare

  // Combinational helpers
  logic [XW-1:0]   cand_x_next;
  logic [YW-1:0]   cand_y_next;
  logic            wall_hit;
  logic            grow_ok;
  logic [LW-1:0]   k_cnt;
  logic            scan_hit;
  logic            commit_load;

  logic [XW-1:0]   seg_x [MAX_LEN];
  logic [YW-1:0]   seg_y [MAX_LEN];

  // ---------------------------------------------------------------------
  // Body storage
  // ---------------------------------------------------------------------
  assign commit_load = (state_reg == ST_COMMIT);

  snake_body_shift #(
    .N       (XW),
    .MAX_LEN (MAX_LEN),
    .INIT    (XW'(INIT_X))
  ) u_body_x (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .load    (commit_load),
    .head_in (cand_x_reg),
    .body    (body_x)
  );

  snake_body_shift #(
    .N       (YW),
    .MAX_LEN (MAX_LEN),
    .INIT    (YW'(INIT_Y))
  ) u_body_y (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .load    (commit_load),
    .head_in (cand_y_reg),
    .body    (body_y)
  );

  // Unpack the flat body so the scan compare can index a segment directly.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
      assign seg_x[gi] = body_x[XW*gi +: XW];
      assign seg_y[gi] = body_y[YW*gi +: YW];
    end
  endgenerate

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  // ---------------------------------------------------------------------
  // Candidate head and wall check. A wall move leaves the candidate at the
  // current head; it is never committed because CALC goes to DEAD.
  // ---------------------------------------------------------------------
  always_comb begin
    cand_x_next = head_x;
    cand_y_next = head_y;
    wall_hit    = 1'b0;
    case (pend_dir_reg)
      DIR_UP: begin
        if (head_y == '0) wall_hit = 1'b1;
        else              cand_y_next = head_y - YW'(1);
      end
      DIR_DOWN: begin
        if (head_y == YW'(Y_MAX)) wall_hit = 1'b1;
        else                      cand_y_next = head_y + YW'(1);
      end
      DIR_LEFT: begin
        if (head_x == '0) wall_hit = 1'b1;
        else              cand_x_next = head_x - XW'(1);
      end
      default: begin
        if (head_x == XW'(X_MAX)) wall_hit = 1'b1;
        else                      cand_x_next = head_x + XW'(1);
      end
    endcase
  end

  // When the snake does not grow, the tail vacates in the same move, so the
  // last segment is excluded from the self-collision scan.
  assign grow_ok  = grow_pend_reg && (length_reg < LW'(MAX_LEN));
  assign k_cnt    = grow_ok ? length_reg : (length_reg - LW'(1));

  assign scan_hit = (seg_x[scan_idx_reg] == cand_x_reg) &&
                    (seg_y[scan_idx_reg] == cand_y_reg);

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_reg     <= ST_WAIT;
      tick_cnt_reg  <= '0;
      pend_dir_reg  <= DIR_RIGHT;
      move_dir_reg  <= DIR_RIGHT;
      dir_reg       <= DIR_RIGHT;
      grow_pend_reg <= 1'b0;
      length_reg    <= LW'(1);
      step_done_reg <= 1'b0;
      game_over_reg <= 1'b0;
      cand_x_reg    <= XW'(INIT_X);
      cand_y_reg    <= YW'(INIT_Y);
      scan_idx_reg  <= '0;
      scan_last_reg <= '0;
    end else begin
      step_done_reg <= 1'b0;

      // Input latches run in every live state. A reversal is judged against
      // the committed direction, not the pending one.
      if (state_reg != ST_DEAD) begin
        if (dir_valid && (dir_req != dir_reverse(dir_reg))) begin
          pend_dir_reg <= dir_req;
        end
        if (grow) begin
          grow_pend_reg <= 1'b1;
        end
      end

      case (state_reg)
        ST_WAIT: begin
          if (tick_cnt_reg == TW'(TICK_DIV-1)) begin
            tick_cnt_reg <= '0;
            state_reg    <= ST_CALC;
          end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
          end
        end

        ST_CALC: begin
          // Freeze the move direction so a request arriving during SCAN is
          // kept for the next move instead of altering this one.
          move_dir_reg  <= pend_dir_reg;
          cand_x_reg    <= cand_x_next;
          cand_y_reg    <= cand_y_next;
          scan_idx_reg  <= '0;
          scan_last_reg <= k_cnt - LW'(1);
          if (wall_hit) begin
            state_reg     <= ST_DEAD;
            game_over_reg <= 1'b1;
          end else if (k_cnt == '0) begin
            state_reg <= ST_COMMIT;
          end else begin
            state_reg <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (scan_hit) begin
            state_reg     <= ST_DEAD;
            game_over_reg <= 1'b1;
          end else if (LW'(scan_idx_reg) == scan_last_reg) begin
            state_reg <= ST_COMMIT;
          end else begin
            scan_idx_reg <= scan_idx_reg + IW'(1);
          end
        end

        ST_COMMIT: begin
          dir_reg <= move_dir_reg;
          if (grow_ok) begin
            length_reg <= length_reg + LW'(1);
          end
          // Consumed (or dropped at full length); a grow pulse arriving in
          // this very cycle carries over to the next move.
          grow_pend_reg <= grow;
          step_done_reg <= 1'b1;
          state_reg     <= ST_WAIT;
        end

        ST_DEAD: begin
          game_over_reg <= 1'b1;
        end

        default: begin
          state_reg <= ST_WAIT;
        end
      endcase
    end
  end

  assign length    = length_reg;
  assign step_done = step_done_reg;
  assign game_over = game_over_reg;
  assign dir       = dir_reg;

endmodule

// File: tb/tb_snake_step_ctrl.sv
module tb_snake_step_ctrl;

  localparam int MAX_LEN  = 4;
  localparam int TICK_DIV = 4;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int LW       = $clog2(MAX_LEN+1);
  localparam int NVEC     = 11;

  logic                  Clock = 1'b0;
  logic                  Resetn = 1'b0;
  logic [1:0]            dir_req = 2'b00;
  logic                  dir_valid = 1'b0;
  logic                  grow = 1'b0;
  logic [XW-1:0]         head_x;
  logic [YW-1:0]         head_y;
  logic [XW*MAX_LEN-1:0] body_x;
  logic [YW*MAX_LEN-1:0] body_y;
  logic [LW-1:0]         length;
  logic                  step_done;
  logic                  game_over;
  logic [1:0]            dir;

  snake_step_ctrl #(
    .MAX_LEN  (MAX_LEN),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .dir_req   (dir_req),
    .dir_valid (dir_valid),
    .grow      (grow),
    .head_x    (head_x),
    .head_y    (head_y),
    .body_x    (body_x),
    .body_y    (body_y),
    .length    (length),
    .step_done (step_done),
    .game_over (game_over),
    .dir       (dir)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       dv;
    logic [1:0] dr;
    logic       gr;
    int         hx;
    int         hy;
    int         len;
    int         dirv;
    int         gap;
  } vec_t;

  vec_t tab [NVEC];
  int   hist_x [NVEC+1];
  int   hist_y [NVEC+1];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for the next step_done, clearing one-cycle input pulses on the
  // first negedge. gap = cycles from the calling cycle to the pulse cycle.
  task automatic wait_step(output int gap);
    bit seen;
    seen = 1'b0;
    gap  = 0;
    while (!seen && gap < 100) begin
      @(negedge Clock);
      gap++;
      dir_valid = 1'b0;
      grow      = 1'b0;
      if (step_done) seen = 1'b1;
    end
    if (!seen) check("step_timeout", 0, 1);
  endtask

  // Holds reset, checks reset values, and releases Resetn so that the
  // cycle the task returns in is the first WAIT cycle (counter 0).
  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_head_x", head_x, 80);
    check("rst_head_y", head_y, 60);
    check("rst_length", length, 1);
    check("rst_dir", dir, 3);
    check("rst_game_over", game_over, 0);
    check("rst_step_done", step_done, 0);
    Resetn = 1'b1;
  endtask

  initial begin
    int gap;
    int pulses;

    // Move table: inputs pulsed in the WAIT cycle that shows the previous
    // step_done; expected head/length/dir and step_done spacing.
    tab[0]  = '{1'b0, 2'b00, 1'b0, 81, 60, 1, 3, 6};
    tab[1]  = '{1'b0, 2'b00, 1'b0, 82, 60, 1, 3, 6};
    tab[2]  = '{1'b0, 2'b00, 1'b0, 83, 60, 1, 3, 6};
    tab[3]  = '{1'b1, 2'b10, 1'b0, 84, 60, 1, 3, 6};  // reversal ignored
    tab[4]  = '{1'b1, 2'b00, 1'b0, 84, 59, 1, 0, 6};  // turn up
    tab[5]  = '{1'b0, 2'b00, 1'b1, 84, 58, 2, 0, 7};  // grow, k=1
    tab[6]  = '{1'b0, 2'b00, 1'b1, 84, 57, 3, 0, 8};  // grow, k=2
    tab[7]  = '{1'b0, 2'b00, 1'b1, 84, 56, 4, 0, 9};  // grow, k=3
    tab[8]  = '{1'b0, 2'b00, 1'b1, 84, 55, 4, 0, 9};  // saturated
    tab[9]  = '{1'b0, 2'b00, 1'b1, 84, 54, 4, 0, 9};  // saturated
    tab[10] = '{1'b0, 2'b00, 1'b0, 84, 53, 4, 0, 9};
    hist_x[0] = 80;
    hist_y[0] = 60;
    for (int n = 0; n < NVEC; n++) begin
      hist_x[n+1] = tab[n].hx;
      hist_y[n+1] = tab[n].hy;
    end

    // ---------------- table-driven moves ----------------
    do_reset();
    for (int n = 0; n < NVEC; n++) begin
      dir_valid = tab[n].dv;
      dir_req   = tab[n].dr;
      grow      = tab[n].gr;
      wait_step(gap);
      $display("move %0d: head=(%0d,%0d) len=%0d dir=%0d gap=%0d",
               n, head_x, head_y, length, dir, gap);
      check("move_head_x", head_x, tab[n].hx);
      check("move_head_y", head_y, tab[n].hy);
      check("move_length", length, tab[n].len);
      check("move_dir", dir, tab[n].dirv);
      check("move_gap", gap, tab[n].gap);
      for (int j = 1; j < tab[n].len; j++) begin
        check("seg_x", int'(body_x[j*XW +: XW]), hist_x[n+1-j]);
        check("seg_y", int'(body_y[j*YW +: YW]), hist_y[n+1-j]);
      end
    end

    // ---------------- right wall ----------------
    do_reset();
    for (int m = 1; m <= 79; m++) begin
      wait_step(gap);
      $display("wall run %0d: head=(%0d,%0d) gap=%0d", m, head_x, head_y, gap);
      check("wall_run_x", head_x, 80 + m);
    end
    // Now in the WAIT cycle of step_done; CALC is 4 cycles later.
    repeat (4) @(negedge Clock);
    check("wall_calc_go", game_over, 0);
    @(negedge Clock);
    check("wall_dead_go", game_over, 1);
    dir_valid = 1'b1;
    dir_req   = 2'b00;
    grow      = 1'b1;
    pulses    = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock);
      dir_valid = 1'b0;
      grow      = 1'b0;
      if (step_done) pulses++;
    end
    $display("wall dead: head=(%0d,%0d) len=%0d go=%0d", head_x, head_y, length, game_over);
    check("dead_pulses", pulses, 0);
    check("dead_head_x", head_x, 159);
    check("dead_head_y", head_y, 60);
    check("dead_length", length, 1);
    check("dead_dir", dir, 3);
    check("dead_sticky", game_over, 1);

    // ---------------- self collision ----------------
    // A request sampled during COMMIT is judged against the direction still
    // committed at that moment, so a down request while the up move commits
    // is accepted and steers the next head back onto segment 1.
    do_reset();
    grow = 1'b1;
    wait_step(gap);
    check("col_grow1_gap", gap, 7);
    check("col_grow1_len", length, 2);
    grow = 1'b1;
    wait_step(gap);
    check("col_grow2_gap", gap, 8);
    check("col_grow2_len", length, 3);
    check("col_grow2_x", head_x, 82);
    dir_valid = 1'b1;                 // cycle X: request up
    dir_req   = 2'b00;
    @(negedge Clock);                 // X+1
    dir_valid = 1'b0;
    repeat (6) @(negedge Clock);      // X+7: COMMIT of the up move
    dir_valid = 1'b1;
    dir_req   = 2'b01;
    @(negedge Clock);                 // X+8: step_done
    dir_valid = 1'b0;
    $display("col up move: head=(%0d,%0d) dir=%0d sd=%0d", head_x, head_y, dir, step_done);
    check("col_up_pulse", step_done, 1);
    check("col_up_y", head_y, 59);
    check("col_up_dir", dir, 0);
    repeat (6) @(negedge Clock);      // X+14: SCAN of segment 1
    check("col_scan_go", game_over, 0);
    @(negedge Clock);                 // X+15
    check("col_dead_go", game_over, 1);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clock);
      if (step_done) pulses++;
    end
    $display("col dead: head=(%0d,%0d) len=%0d go=%0d", head_x, head_y, length, game_over);
    check("col_pulses", pulses, 0);
    check("col_head_x", head_x, 82);
    check("col_head_y", head_y, 59);
    check("col_length", length, 3);

    // ---------------- reset during SCAN ----------------
    do_reset();
    grow      = 1'b1;                 // c0: grow and an up request
    dir_valid = 1'b1;
    dir_req   = 2'b00;
    @(negedge Clock);                 // c1
    grow      = 1'b0;
    dir_valid = 1'b0;
    repeat (4) @(negedge Clock);      // c5: SCAN (k=1)
    Resetn = 1'b0;
    @(negedge Clock);                 // c6: reset values
    $display("mid reset: head=(%0d,%0d) len=%0d dir=%0d go=%0d",
             head_x, head_y, length, dir, game_over);
    check("mrst_length", length, 1);
    check("mrst_head_x", head_x, 80);
    check("mrst_head_y", head_y, 60);
    check("mrst_game_over", game_over, 0);
    check("mrst_dir", dir, 3);
    check("mrst_step_done", step_done, 0);
    Resetn = 1'b1;
    wait_step(gap);
    $display("after reset: head=(%0d,%0d) len=%0d gap=%0d", head_x, head_y, length, gap);
    check("mrst_next_gap", gap, 6);
    check("mrst_next_x", head_x, 81);
    check("mrst_next_y", head_y, 60);
    check("mrst_next_len", length, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
